// File: rtl/pipelined_array_multiplier_pipe_reg.sv
// Pipeline register that sits between two stages of a pipelined array multiplier.
// It captures the stage outputs of the feeding stage and consumes PRODUCT_PER_STAGE
// multiplier bits. It also inserts the feeding stage's finished result bits into
// their slot of the accumulated low product.
//
// Handshake: an item moves on an edge where valid and ready are both 1. ready_o is
// ~valid_o | ready_i, so a full register still accepts new data in the same cycle it
// drains. Under a continuous stream this gives one item per cycle with no bubbles.
// While valid_o=1 and ready_i=0 the register holds, and every output stays stable.
module pipelined_array_multiplier_pipe_reg #(
  parameter int DATA_WIDTH        = 8,
  parameter int PRODUCT_PER_STAGE = 4,
  parameter int STAGE_INDEX       = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [DATA_WIDTH-1:0]         operand_A_i,
  input  logic [DATA_WIDTH-1:0]         operand_B_rem_i,
  input  logic [DATA_WIDTH-2:0]         partial_product_i,
  input  logic                          carry_i,
  input  logic [PRODUCT_PER_STAGE-1:0]  result_bits_i,
  input  logic [DATA_WIDTH-1:0]         result_low_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [DATA_WIDTH-1:0]         operand_A_o,
  output logic [DATA_WIDTH-1:0]         operand_B_rem_o,
  output logic [DATA_WIDTH-2:0]         partial_product_o,
  output logic                          carry_o,
  output logic [DATA_WIDTH-1:0]         result_low_o,
  output logic [2*DATA_WIDTH-1:0]       product_o
);

  // Bit position of this stage's slot inside the accumulated low product.
  localparam int SLOT_LSB = STAGE_INDEX * PRODUCT_PER_STAGE;

  logic                  transfer;
  logic [DATA_WIDTH-1:0] operand_B_rem_next;
  logic [DATA_WIDTH-1:0] result_low_next;

  // The register accepts when empty or when its current item leaves this cycle.
  assign ready_o  = ~valid_o | ready_i;
  assign transfer = valid_i & ready_o;

  // Values to load on a transfer: drop the consumed multiplier bits and drop the
  // finished result bits into their slot; everything else passes through.
  always_comb begin
    operand_B_rem_next = operand_B_rem_i >> PRODUCT_PER_STAGE;
    result_low_next    = result_low_i;
    result_low_next[SLOT_LSB +: PRODUCT_PER_STAGE] = result_bits_i;
  end

  // Valid flag: set on a transfer, cleared when drained, held while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
    end else if (transfer) begin
      valid_o <= 1'b1;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

  // Data registers: load only on a transfer, so they hold during stalls and idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      operand_A_o       <= '0;
      operand_B_rem_o   <= '0;
      partial_product_o <= '0;
      carry_o           <= 1'b0;
      result_low_o      <= '0;
    end else if (transfer) begin
      operand_A_o       <= operand_A_i;
      operand_B_rem_o   <= operand_B_rem_next;
      partial_product_o <= partial_product_i;
      carry_o           <= carry_i;
      result_low_o      <= result_low_next;
    end
  end

  // The full product is taken straight from the registers. On the last stage the
  // carry, partial product and low bits form the complete 2*DATA_WIDTH result.
  assign product_o = {carry_o, partial_product_o, result_low_o};

endmodule

// File: tb/tb_pipelined_array_multiplier_pipe_reg.sv
// Bench for the multiplier pipeline register. Two instances (STAGE_INDEX 0 and 1)
// share one input stream. Each instance has its own scoreboard and monitor, which
// compare the outputs against a reference model of the stage.
module tb_pipelined_array_multiplier_pipe_reg;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [6:0] pp;
    logic       c;
    logic [7:0] rl;
  } item_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic       valid_i = 1'b0;
  logic       ready_i = 1'b1;
  logic [7:0] a_i     = '0;
  logic [7:0] b_i     = '0;
  logic [6:0] pp_i    = '0;
  logic       c_i     = 1'b0;
  logic [3:0] rb_i    = '0;
  logic [7:0] rl_i    = '0;

  // ---------------- per-instance outputs ----------------
  logic        ready_o [2];
  logic        valid_o [2];
  logic [7:0]  a_o     [2];
  logic [7:0]  b_o     [2];
  logic [6:0]  pp_o    [2];
  logic        c_o     [2];
  logic [7:0]  rl_o    [2];
  logic [15:0] prod_o  [2];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model for one stage. It divides the multiplier remainder by 16 to drop
  // the consumed bits. It rebuilds the low product by subtracting the old digit in
  // base 16 at this stage's position and adding the new one.
  function automatic item_t model(input int s, input logic [7:0] a, input logic [7:0] b,
                                  input logic [6:0] pp, input logic c,
                                  input logic [3:0] rb, input logic [7:0] rl);
    item_t r;
    int unsigned weight;
    int unsigned old_digit;
    int unsigned low;
    weight    = 16 ** s;
    old_digit = (32'(rl) / weight) % 16;
    low       = 32'(rl) - old_digit * weight + 32'(rb) * weight;
    r.a  = a;
    r.b  = 8'(32'(b) / 16);
    r.pp = pp;
    r.c  = c;
    r.rl = low[7:0];
    return r;
  endfunction

  // ---------------- DUTs, scoreboards and monitors ----------------
  for (genvar g = 0; g < 2; g++) begin : lane
    pipelined_array_multiplier_pipe_reg #(
      .DATA_WIDTH(8), .PRODUCT_PER_STAGE(4), .STAGE_INDEX(g)
    ) dut (
      .clk_i(clk), .rst_i(rst),
      .valid_i(valid_i), .ready_o(ready_o[g]),
      .operand_A_i(a_i), .operand_B_rem_i(b_i), .partial_product_i(pp_i),
      .carry_i(c_i), .result_bits_i(rb_i), .result_low_i(rl_i),
      .valid_o(valid_o[g]), .ready_i(ready_i),
      .operand_A_o(a_o[g]), .operand_B_rem_o(b_o[g]), .partial_product_o(pp_o[g]),
      .carry_o(c_o[g]), .result_low_o(rl_o[g]), .product_o(prod_o[g])
    );

    item_t exp_q[$];
    item_t last  = '0;
    bit    armed = 1'b0;

    // Midway between edges: compare what the register should hold now, then predict
    // what the coming edge will do with the inputs presently driven.
    always @(negedge clk) begin
      item_t e;
      bit    full;
      string pfx;
      pfx  = $sformatf("lane%0d", g);
      full = (exp_q.size() > 0);
      e    = full ? exp_q[0] : last;
      if (armed) begin
        chk({pfx, " valid_o"}, 32'(valid_o[g]), 32'(full));
        chk({pfx, " ready_o"}, 32'(ready_o[g]), 32'(!full || ready_i));
        chk({pfx, " operand_A_o"}, 32'(a_o[g]), 32'(e.a));
        chk({pfx, " operand_B_rem_o"}, 32'(b_o[g]), 32'(e.b));
        chk({pfx, " partial_product_o"}, 32'(pp_o[g]), 32'(e.pp));
        chk({pfx, " carry_o"}, 32'(c_o[g]), 32'(e.c));
        chk({pfx, " result_low_o"}, 32'(rl_o[g]), 32'(e.rl));
        chk({pfx, " product_o"}, 32'(prod_o[g]), 32'({e.c, e.pp, e.rl}));
      end
      if (rst) begin
        exp_q.delete();
        last  = '0;
        armed = 1'b1;
      end else if (armed) begin
        if (full && ready_i) last = exp_q.pop_front();
        if (valid_i && (!full || ready_i))
          exp_q.push_back(model(g, a_i, b_i, pp_i, c_i, rb_i, rl_i));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic r);
    valid_i = v;
    ready_i = r;
    a_i     = 8'($urandom_range(0, 255));
    b_i     = 8'($urandom_range(0, 255));
    pp_i    = 7'($urandom_range(0, 127));
    c_i     = 1'($urandom_range(0, 1));
    rb_i    = 4'($urandom_range(0, 15));
    rl_i    = 8'($urandom_range(0, 255));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int run;

    // Reset with valid data presented: everything must stay cleared.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)));
      cycle();
    end
    for (int g = 0; g < 2; g++) begin
      chk("reset valid_o", 32'(valid_o[g]), 32'd0);
      chk("reset ready_o", 32'(ready_o[g]), 32'd1);
      chk("reset product_o", 32'(prod_o[g]), 32'd0);
    end

    // Stage 0 single transfer, accepted on the first edge out of reset.
    rst = 1'b0;
    drive(1'b1, 1'b1);
    a_i = 8'hB5; b_i = 8'hC3; rb_i = 4'h9; rl_i = 8'h00;
    cycle();
    chk("s0 valid_o", 32'(valid_o[0]), 32'd1);
    chk("s0 operand_A_o", 32'(a_o[0]), 32'hB5);
    chk("s0 operand_B_rem_o", 32'(b_o[0]), 32'h0C);
    chk("s0 result_low_o", 32'(rl_o[0]), 32'h09);

    // Stage 1 product assembly.
    drive(1'b1, 1'b1);
    c_i = 1'b1; pp_i = 7'h2A; rb_i = 4'h5; rl_i = 8'h0C;
    cycle();
    chk("s1 result_low_o", 32'(rl_o[1]), 32'h5C);
    chk("s1 product_o", 32'(prod_o[1]), 32'hAA5C);

    // Random valid/ready traffic.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
      cycle();
    end

    // Stall for 5 cycles while the inputs keep changing.
    drive(1'b1, 1'b1);
    cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0);
      cycle();
      chk("stall ready_o", 32'(ready_o[0]), 32'd0);
      chk("stall valid_o", 32'(valid_o[0]), 32'd1);
    end
    drive(1'b1, 1'b1);
    cycle();
    chk("release valid_o", 32'(valid_o[0]), 32'd1);

    // Back-to-back stream of 10 items.
    drive(1'b0, 1'b1);
    cycle();
    run = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1);
      cycle();
      if (valid_o[0]) run++;
    end
    chk("b2b valid run", 32'(run), 32'd10);

    // Same stream with a one-cycle reset in the middle.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1);
      rst = (i == 5);
      cycle();
      if (i == 5) chk("midreset valid_o", 32'(valid_o[0]), 32'd0);
      if (i == 6) chk("post-reset valid_o", 32'(valid_o[0]), 32'd1);
    end
    rst = 1'b0;

    // Drain.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_array_multiplier_pipe_reg.md
PIPELINED_ARRAY_MULTIPLIER_PIPE_REG -- requirements
Module: pipelined_array_multiplier_pipe_reg

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk_i.
REQ-002 Parameters SHALL be:
- DATA_WIDTH, default 8, operand width; power of 2.
- PRODUCT_PER_STAGE, default 4, result bits produced per stage; power of 2, divides DATA_WIDTH.
- STAGE_INDEX, default 0, position of the feeding stage, range 0 to DATA_WIDTH/PRODUCT_PER_STAGE-1.
REQ-003 Ports SHALL be, with direction and width:
- clk_i, in, 1: clock.
- rst_i, in, 1: synchronous active-high reset.
- valid_i, in, 1: upstream stage outputs are valid.
- ready_o, out, 1: register can accept this cycle.
- operand_A_i, in, DATA_WIDTH: multiplicand travelling with the data.
- operand_B_rem_i, in, DATA_WIDTH: unconsumed multiplier bits; the LSBs are the ones the feeding stage used.
- partial_product_i, in, DATA_WIDTH-1: partial_product_o of the feeding stage.
- carry_i, in, 1: carry_o of the feeding stage.
- result_bits_i, in, PRODUCT_PER_STAGE: final_result_bits_o of the feeding stage.
- result_low_i, in, DATA_WIDTH: low product bits accumulated so far.
- valid_o, out, 1: registered data valid.
- ready_i, in, 1: downstream can accept.
- operand_A_o, out, DATA_WIDTH: registered multiplicand.
- operand_B_rem_o, out, DATA_WIDTH: registered multiplier remainder.
- partial_product_o, out, DATA_WIDTH-1: registered partial product.
- carry_o, out, 1: registered carry.
- result_low_o, out, DATA_WIDTH: registered accumulated low bits.
- product_o, out, 2*DATA_WIDTH: full product; meaningful only on the last stage.

Function
REQ-004 ready_o SHALL equal ~valid_o | ready_i, combinationally, with no bubble under a continuous stream.
REQ-005 A transfer SHALL occur when valid_i & ready_o; on a transfer all data registers SHALL load in the same edge and valid_o SHALL become 1.
REQ-006 When there is no transfer and ready_i=1, valid_o SHALL become 0 and the data registers SHALL hold their values.
REQ-007 When valid_o=1 and ready_i=0, every output SHALL hold stable; this covers stall of any length.
REQ-008 Simultaneous drain and fill (valid_o=1, ready_i=1, valid_i=1) SHALL load the new data and keep valid_o=1.
REQ-009 operand_A_o SHALL load operand_A_i unchanged.
REQ-010 operand_B_rem_o SHALL load operand_B_rem_i logically shifted right by PRODUCT_PER_STAGE, zero-filled.
REQ-011 partial_product_o and carry_o SHALL load partial_product_i and carry_i unchanged.
REQ-012 result_low_o SHALL load result_low_i with bits [(STAGE_INDEX+1)*PRODUCT_PER_STAGE-1 : STAGE_INDEX*PRODUCT_PER_STAGE] replaced by result_bits_i; all other bits SHALL be copied.
REQ-013 product_o SHALL be combinational from the registers as {carry_o, partial_product_o, result_low_o}.
REQ-014 Latency SHALL be one cycle from the accepted input to valid_o; throughput SHALL be one item per cycle.
REQ-015 The outputs SHALL be independent of inputs while valid_o=1 and ready_i=0; there SHALL be no combinational path from data inputs to data outputs.

Reset
REQ-016 While rst_i=1, at each edge:
- valid_o, carry_o, operand_A_o, operand_B_rem_o, partial_product_o and result_low_o SHALL become 0.
- Consequently product_o SHALL read 0 and ready_o SHALL read 1.
REQ-017 Reset SHALL take priority over a simultaneous transfer, and in-flight data SHALL be discarded.
REQ-018 The first transfer SHALL be accepted on the first edge with rst_i=0.

Verification (DATA_WIDTH=8, PRODUCT_PER_STAGE=4)
REQ-019 Reset: assert rst_i with valid_i=1 and random data -> valid_o=0 and all outputs 0 during reset; ready_o=1.
REQ-020 STAGE_INDEX=0 single transfer: operand_A_i=0xB5, operand_B_rem_i=0xC3, result_bits_i=0x9, result_low_i=0x00, ready_i=1. Required response, one cycle later:
- valid_o=1.
- operand_A_o=0xB5.
- operand_B_rem_o=0x0C.
- result_low_o=0x09.
REQ-021 STAGE_INDEX=1 product: carry_i=1, partial_product_i=0x2A, result_bits_i=0x5, result_low_i=0x0C -> result_low_o=0x5C, product_o=0xAA5C.
REQ-022 Stall: hold ready_i=0 for 5 cycles with valid_o=1 and changing inputs -> outputs frozen, ready_o=0. On release, the next queued item transfers in one cycle.
REQ-023 Back-to-back: 10 items with valid_i=1 and ready_i=1 every cycle -> 10 consecutive valid_o cycles, data in order, no gaps.
REQ-024 Mid-stream reset: assert rst_i for 1 cycle in the middle of REQ-023 -> valid_o=0 the next cycle. The first post-reset item emerges after one cycle.
